// File: rtl/lfsr_debruijn_gen.sv
// lfsr_debruijn_gen
// Galois-XNOR LFSR extended into a de Bruijn counter: the all-ones lockup state
// is spliced into the maximal-length cycle, so a primitive TAPS set visits all
// 2^WIDTH states. Supports seed load, forward/reverse stepping, a counted burst
// engine, and a position counter plus wrap pulse relative to the loaded anchor.
//
// Ports:
//   clk       clock
//   reset     asynchronous, active-high reset
//   enable_i  single step per cycle while idle
//   dir_i     0 = forward, 1 = reverse (sampled on every step)
//   load_i    load seed_i into out and anchor, abort any burst
//   seed_i    load value
//   start_i   begin burst of len_i steps (ignored while busy)
//   len_i     burst step count, 0..2^WIDTH
//   out_o     current state
//   pos_o     signed step distance from anchor, mod 2^WIDTH
//   busy_o    burst in progress
//   done_o    one-cycle pulse after the final burst step
//   wrap_o    one-cycle pulse when a step lands on the anchor
module lfsr_debruijn_gen #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'h1C
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             start_i,
    input  logic [WIDTH:0]   len_i,
    output logic [WIDTH-1:0] out_o,
    output logic [WIDTH-1:0] pos_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             wrap_o
);

    localparam logic StIdle = 1'b0;
    localparam logic StRun  = 1'b1;

    logic             state_q, state_d;
    logic [WIDTH:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] anchor_q, anchor_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;

    logic             fwd_fb;
    logic [WIDTH-1:0] fwd_next;
    logic             rev_fb;
    logic [WIDTH-2:0] rev_low;
    logic [WIDTH-1:0] rev_next;
    logic             step;

    // Forward step. The AND term flips feedback on the two states whose low
    // bits are all ones, which splices all-ones into the cycle.
    always_comb begin
        fwd_fb      = out_q[WIDTH-1] ^ (&out_q[WIDTH-2:0]);
        fwd_next    = '0;
        fwd_next[0] = fwd_fb;
        for (int i = 1; i < WIDTH; i++) begin
            fwd_next[i] = TAPS[i] ? ~(fwd_fb ^ out_q[i-1]) : out_q[i-1];
        end
    end

    // Reverse step: undo the taps using the feedback bit now sitting in bit 0,
    // then rebuild the shifted-out MSB from the recovered low bits.
    always_comb begin
        rev_fb  = out_q[0];
        rev_low = '0;
        for (int i = 1; i < WIDTH; i++) begin
            rev_low[i-1] = TAPS[i] ? ~(rev_fb ^ out_q[i]) : out_q[i];
        end
        rev_next = {rev_fb ^ (&rev_low), rev_low};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        anchor_d = anchor_q;
        pos_d    = pos_q;
        done_d   = 1'b0;
        wrap_d   = 1'b0;
        step     = 1'b0;

        if (load_i) begin
            out_d    = seed_i;
            anchor_d = seed_i;
            pos_d    = '0;
            state_d  = StIdle;
        end else if (state_q == StIdle) begin
            if (start_i) begin
                if (len_i != '0) begin
                    cnt_d   = len_i;
                    state_d = StRun;
                end else begin
                    done_d = 1'b1;
                end
            end else if (enable_i) begin
                step = 1'b1;
            end
        end else begin
            step  = 1'b1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == {{WIDTH{1'b0}}, 1'b1}) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
        end

        if (step) begin
            out_d  = dir_i ? rev_next : fwd_next;
            pos_d  = dir_i ? (pos_q - 1'b1) : (pos_q + 1'b1);
            wrap_d = (out_d == anchor_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            out_q    <= '0;
            anchor_q <= '0;
            pos_q    <= '0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            anchor_q <= anchor_d;
            pos_q    <= pos_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
        end
    end

    assign out_o  = out_q;
    assign pos_o  = pos_q;
    assign busy_o = (state_q == StRun);
    assign done_o = done_q;
    assign wrap_o = wrap_q;

endmodule

// File: tb/tb_lfsr_debruijn_gen.sv
// Testbench for lfsr_debruijn_gen: WIDTH=8 main instance plus WIDTH=3 and
// WIDTH=16 instances for full-period checks. Expected values come from an
// arithmetic model of the step rule; reverse steps are found by searching for
// the predecessor under the forward rule.
module tb_lfsr_debruijn_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // WIDTH = 8 instance
    logic       en8 = 0, dir8 = 0, ld8 = 0, st8 = 0;
    logic [7:0] seed8 = '0;
    logic [8:0] len8 = '0;
    logic [7:0] out8, pos8;
    logic       busy8, done8, wrap8;

    // WIDTH = 3 instance
    logic       ld3 = 0, st3 = 0;
    logic [2:0] seed3 = '0;
    logic [3:0] len3 = '0;
    logic [2:0] out3, pos3;
    logic       busy3, done3, wrap3;

    // WIDTH = 16 instance
    logic        ld16 = 0, st16 = 0;
    logic [15:0] seed16 = '0;
    logic [16:0] len16 = '0;
    logic [15:0] out16, pos16;
    logic        busy16, done16, wrap16;

    lfsr_debruijn_gen #(.WIDTH(8), .TAPS(8'h1C)) dut8 (
        .clk(clk), .reset(rst), .enable_i(en8), .dir_i(dir8), .load_i(ld8),
        .seed_i(seed8), .start_i(st8), .len_i(len8), .out_o(out8), .pos_o(pos8),
        .busy_o(busy8), .done_o(done8), .wrap_o(wrap8)
    );

    lfsr_debruijn_gen #(.WIDTH(3), .TAPS(3'b010)) dut3 (
        .clk(clk), .reset(rst), .enable_i(1'b0), .dir_i(1'b0), .load_i(ld3),
        .seed_i(seed3), .start_i(st3), .len_i(len3), .out_o(out3), .pos_o(pos3),
        .busy_o(busy3), .done_o(done3), .wrap_o(wrap3)
    );

    lfsr_debruijn_gen #(.WIDTH(16), .TAPS(16'h002C)) dut16 (
        .clk(clk), .reset(rst), .enable_i(1'b0), .dir_i(1'b0), .load_i(ld16),
        .seed_i(seed16), .start_i(st16), .len_i(len16), .out_o(out16), .pos_o(pos16),
        .busy_o(busy16), .done_o(done16), .wrap_o(wrap16)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state for the WIDTH = 8 instance
    int unsigned m_out = 0, m_pos = 0, m_anc = 0, m_wrap = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Successor under the forward rule, as shift-in-feedback then a tap mask
    // applied only when the feedback bit is zero.
    function automatic int unsigned fwd(input int unsigned s, input int unsigned w,
                                        input int unsigned taps);
        int unsigned mask, low, fb;
        mask = (32'd1 << w) - 32'd1;
        low  = (32'd1 << (w - 1)) - 32'd1;
        fb   = ((s >> (w - 1)) & 32'd1) ^ (((s & low) == low) ? 32'd1 : 32'd0);
        return (((s << 1) | fb) ^ ((fb != 0) ? 32'd0 : (taps & ~32'd1))) & mask;
    endfunction

    function automatic int unsigned rev8(input int unsigned s);
        for (int unsigned r = 0; r < 256; r++) begin
            if (fwd(r, 8, 32'h1C) == s) return r;
        end
        return 32'hFFFF_FFFF;
    endfunction

    task automatic model_step(input bit d);
        m_out  = d ? rev8(m_out) : fwd(m_out, 8, 32'h1C);
        m_pos  = (m_pos + (d ? 32'd255 : 32'd1)) & 32'hFF;
        m_wrap = (m_out == m_anc) ? 1 : 0;
    endtask

    task automatic model_load(input int unsigned s);
        m_out  = s;
        m_anc  = s;
        m_pos  = 0;
        m_wrap = 0;
    endtask

    task automatic check_state8(input string tag);
        check({tag, ".out"},  {24'd0, out8}, m_out);
        check({tag, ".pos"},  {24'd0, pos8}, m_pos);
        check({tag, ".wrap"}, {31'd0, wrap8}, m_wrap);
    endtask

    bit seen8 [0:255];
    bit seen3 [0:7];
    bit seen16 [0:65535];

    initial begin
        int unsigned nsteps, sav_out, sav_pos, busy_cnt, uniq, bad, dup, s;

        // Reset values, while asserted and after release
        repeat (2) tick();
        check("rst.out", {24'd0, out8}, 0);
        check("rst.pos", {24'd0, pos8}, 0);
        check("rst.busy", {31'd0, busy8}, 0);
        check("rst.done", {31'd0, done8}, 0);
        check("rst.wrap", {31'd0, wrap8}, 0);
        rst = 1'b0;
        tick();
        check("idle.out", {24'd0, out8}, 0);

        // Directed forward steps from zero
        en8 = 1; dir8 = 0;
        tick(); model_step(0);
        check("fwd1.out", {24'd0, out8}, 32'h1C);
        check("fwd1.pos", {24'd0, pos8}, 1);
        tick(); model_step(0);
        check("fwd2.out", {24'd0, out8}, 32'h24);
        check("fwd2.pos", {24'd0, pos8}, 2);

        // Load 0x1C, one reverse step lands on 0x00 with pos = -1
        en8 = 0; ld8 = 1; seed8 = 8'h1C;
        tick(); model_load(32'h1C);
        ld8 = 0; en8 = 1; dir8 = 1;
        tick(); model_step(1);
        check("rev1.out", {24'd0, out8}, 32'h00);
        check("rev1.pos", {24'd0, pos8}, 32'hFF);
        en8 = 0;
        tick(); m_wrap = 0;

        // 1000 forward steps with random enable gaps, then the same count back
        sav_out = m_out; sav_pos = m_pos;
        nsteps = 0; dir8 = 0;
        for (int i = 0; i < 4000 && nsteps < 1000; i++) begin
            en8 = ($urandom_range(0, 3) != 0);
            tick();
            if (en8) begin model_step(0); nsteps++; end
            else m_wrap = 0;
            check_state8("rndfwd");
        end
        dir8 = 1;
        for (int i = 0; i < 4000 && nsteps > 0; i++) begin
            en8 = ($urandom_range(0, 3) != 0);
            tick();
            if (en8) begin model_step(1); nsteps--; end
            else m_wrap = 0;
            check_state8("rndrev");
        end
        en8 = 0;
        check("restore.steps", nsteps, 0);
        check("restore.out", {24'd0, out8}, sav_out);
        check("restore.pos", {24'd0, pos8}, sav_pos);

        // Full-period burst from 0xA5; start and enable asserted mid-burst
        dir8 = 0; ld8 = 1; seed8 = 8'hA5;
        tick(); model_load(32'hA5);
        ld8 = 0; st8 = 1; len8 = 9'd256;
        tick(); m_wrap = 0;
        st8 = 0;
        check("burst.busy0", {31'd0, busy8}, 1);
        check("burst.hold", {24'd0, out8}, 32'hA5);
        for (int i = 0; i < 256; i++) seen8[i] = 0;
        busy_cnt = busy8 ? 1 : 0;
        uniq = 0;
        for (int k = 1; k <= 256; k++) begin
            if (k == 100) begin st8 = 1; len8 = 9'd5; en8 = 1; end
            tick();
            st8 = 0; en8 = 0;
            model_step(0);
            check("burst.out", {24'd0, out8}, m_out);
            if (!seen8[out8]) uniq++;
            seen8[out8] = 1;
            if (busy8) busy_cnt++;
            if (k < 256) begin
                check("burst.done_lo", {31'd0, done8}, 0);
                check("burst.wrap_lo", {31'd0, wrap8}, 0);
            end
        end
        check("burst.busy_cycles", busy_cnt, 256);
        check("burst.unique", uniq, 256);
        check("burst.saw_ff", {31'd0, seen8[255]}, 1);
        check("burst.end_out", {24'd0, out8}, 32'hA5);
        check("burst.end_pos", {24'd0, pos8}, 0);
        check("burst.end_wrap", {31'd0, wrap8}, 1);
        check("burst.end_done", {31'd0, done8}, 1);
        check("burst.end_busy", {31'd0, busy8}, 0);
        tick(); m_wrap = 0;
        check("burst.done_pulse", {31'd0, done8}, 0);

        // Zero-length burst
        st8 = 1; len8 = 9'd0;
        tick();
        st8 = 0;
        check("len0.busy", {31'd0, busy8}, 0);
        check("len0.done", {31'd0, done8}, 1);
        check("len0.out", {24'd0, out8}, m_out);
        tick();
        check("len0.done_pulse", {31'd0, done8}, 0);

        // Mid-burst load with random direction changes
        st8 = 1; len8 = 9'd50;
        tick();
        st8 = 0;
        for (int k = 0; k < 20; k++) begin
            dir8 = 1'($urandom_range(0, 1));
            tick();
            model_step(dir8);
            check_state8("dirmix");
        end
        ld8 = 1; seed8 = 8'h3C;
        tick(); model_load(32'h3C);
        ld8 = 0;
        check_state8("midload");
        check("midload.busy", {31'd0, busy8}, 0);
        check("midload.done", {31'd0, done8}, 0);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done8 !== 1'b0 || busy8 !== 1'b0 || out8 !== 8'h3C) bad++;
        end
        check("midload.quiet", bad, 0);

        // load and start together: load wins
        ld8 = 1; st8 = 1; len8 = 9'd10; seed8 = 8'h5A;
        tick(); model_load(32'h5A);
        ld8 = 0; st8 = 0;
        check("ldst.busy", {31'd0, busy8}, 0);
        check("ldst.out", {24'd0, out8}, 32'h5A);
        tick();
        check("ldst.still", {24'd0, out8}, 32'h5A);

        // Asynchronous reset mid-burst
        dir8 = 0; st8 = 1; len8 = 9'd100;
        tick();
        st8 = 0;
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        check("arst.out", {24'd0, out8}, 0);
        check("arst.pos", {24'd0, pos8}, 0);
        check("arst.busy", {31'd0, busy8}, 0);
        check("arst.done", {31'd0, done8}, 0);
        check("arst.wrap", {31'd0, wrap8}, 0);
        tick();
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done8 !== 1'b0 || busy8 !== 1'b0) bad++;
        end
        check("arst.no_done", bad, 0);

        // WIDTH = 3 full period
        seed3 = 3'($urandom_range(0, 7));
        ld3 = 1;
        tick();
        ld3 = 0; st3 = 1; len3 = 4'd8;
        tick();
        st3 = 0;
        check("w3.busy0", {31'd0, busy3}, 1);
        for (int i = 0; i < 8; i++) seen3[i] = 0;
        s = {29'd0, seed3}; bad = 0; dup = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            s = fwd(s, 3, 32'h2);
            if ({29'd0, out3} !== s) bad++;
            if (seen3[out3]) dup++;
            seen3[out3] = 1;
            if (busy3 !== (k < 8)) bad++;
            if (wrap3 !== (k == 8)) bad++;
            if (done3 !== (k == 8)) bad++;
        end
        check("w3.model", bad, 0);
        check("w3.dups", dup, 0);
        check("w3.return", {29'd0, out3}, {29'd0, seed3});
        check("w3.pos", {29'd0, pos3}, 0);

        // WIDTH = 16 full period
        seed16 = 16'($urandom_range(0, 65535));
        ld16 = 1;
        tick();
        ld16 = 0; st16 = 1; len16 = 17'h10000;
        tick();
        st16 = 0;
        check("w16.busy0", {31'd0, busy16}, 1);
        for (int i = 0; i < 65536; i++) seen16[i] = 0;
        s = {16'd0, seed16}; bad = 0; dup = 0;
        for (int k = 1; k <= 65536; k++) begin
            tick();
            s = fwd(s, 16, 32'h2C);
            if ({16'd0, out16} !== s) bad++;
            if (seen16[out16]) dup++;
            seen16[out16] = 1;
            if (busy16 !== (k < 65536)) bad++;
            if (wrap16 !== (k == 65536)) bad++;
            if (done16 !== (k == 65536)) bad++;
        end
        check("w16.model", bad, 0);
        check("w16.dups", dup, 0);
        check("w16.return", {16'd0, out16}, {16'd0, seed16});
        check("w16.pos", {16'd0, pos16}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lfsr_debruijn_gen.md
# lfsr_debruijn_gen

Parametrised Galois-XNOR de Bruijn sequence generator. Any primitive tap set of width WIDTH cycles through all 2^WIDTH states, including the all-ones lockup state that a plain XNOR LFSR never reaches. Adds four things to the fixed 8-bit generator:

- seed load
- forward and reverse stepping
- a burst engine that runs a programmed step count
- a position counter and a wrap pulse relative to the loaded anchor

The block is used as a pattern source for BIST, scramblers and address sweeps.

## Interface

- WIDTH, 8, register width; legal 3..16
- TAPS, 8'h1C, Galois tap mask (bit i set: out[i] takes an XNOR with fb). TAPS[0] is ignored. Must be primitive for WIDTH.
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- enable  in  1  single step per cycle while idle
- dir  in  1  0 = forward, 1 = reverse; sampled on every step
- load  in  1  load seed into out and anchor
- seed  in  WIDTH  load value
- start  in  1  begin burst (ignored while busy)
- len  in  WIDTH+1  burst step count, 0..2^WIDTH
- out  out  WIDTH  current state
- pos  out  WIDTH  signed step distance from anchor, mod 2^WIDTH
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse on the cycle after the final burst step
- wrap  out  1  one-cycle pulse when a step lands on the anchor

## Operation

**Forward step**
- fb = out[W-1] ^ &out[W-2:0].
- out[0] <= fb.
- For i = 1..W-1: out[i] <= TAPS[i] ? ~(fb ^ out[i-1]) : out[i-1].
- pos <= pos + 1.

**Reverse step** (exact inverse of the forward step)
- fb = out[0].
- For i = 1..W-1: p[i-1] = TAPS[i] ? ~(fb ^ out[i]) : out[i].
- p[W-1] = fb ^ &p[W-2:0].
- out <= p; pos <= pos - 1.

**Priority per cycle:** load > start > burst step > enable step.

**Load**
- out <= seed, anchor <= seed, pos <= 0.
- Aborts any burst: busy <= 0, and no done pulse is generated.

**Burst FSM: IDLE / RUN**
- IDLE, start, len != 0: latch the counter to len, go to RUN, busy <= 1. Stepping starts on the next cycle.
- IDLE, start, len == 0: stay in IDLE and pulse done on the next cycle.
- RUN: one step per cycle using the current dir; the counter decrements. When the counter reaches 1 and that step executes, go to IDLE, busy <= 0, and set done <= 1 for one cycle.
- enable and start are ignored in RUN.

**wrap**
- Registered. High for one cycle after any step (single or burst) whose result equals anchor.
- Not raised by load.

**Widths and arithmetic**
- pos wraps mod 2^WIDTH.
- len = 2^WIDTH runs exactly one full period.

## Timing

- Reset values: out = 0, anchor = 0, pos = 0, busy = 0, done = 0, wrap = 0, FSM = IDLE.
- Every output is registered. out and pos update on the clock edge where the step qualifies, so latency is 1 cycle.
- wrap and done assert in the same cycle as the out value that caused them.
- Burst of len N: busy is high for N cycles starting the cycle after start; done is high in the cycle busy falls.
- Reset asserted mid-burst: immediate return to reset values. No done pulse follows.
- A dir change mid-burst takes effect on the next step.
- load and start in the same cycle: load wins and start is dropped.
- Full period: the forward sequence from any state returns to that state after exactly 2^WIDTH steps and visits every state once, including all-ones.

## Test plan

- Reset, then enable with dir = 0 (WIDTH = 8, TAPS = 8'h1C) -> out 0x00 → 0x1C → 0x24; pos 0 → 1 → 2.
- From out = 0x1C, one reverse step -> out = 0x00 and pos = 0xFF. Then forward 1000 random steps and reverse the same count -> out and pos restored.
- load seed = 0xA5, then start with len = 256 -> busy high for 256 cycles; all 256 states seen exactly once (scoreboard), including 0xFF. wrap and done both pulse on the final cycle with out = 0xA5 and pos = 0.
- start with len = 0 -> busy stays 0 and done pulses in the next cycle. Assert start while busy -> ignored, and the counter is unaffected.
- Mid-burst load seed = 0x3C -> out = 0x3C, pos = 0, busy = 0, no done pulse. Assert async reset mid-burst -> all outputs 0 immediately.
- Parameter sweep WIDTH = 3 (TAPS = 3'b010) and WIDTH = 16 (TAPS = 16'h002C after a primitivity check) -> the period equals 2^WIDTH with no repeated state.
